// File: rtl/mode_ctrl_57.sv
// Mode controller for a digital clock: debounces four push-buttons and steps
// RUN/CORRECT/ALARM/STOPWATCH, with field select, gated key strobes and idle timeout.
module mode_ctrl_57 #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int TIMEOUT_S    = 30
) (
  input  logic       clk_50m_57,
  input  logic       rst_n_57,
  input  logic       clk_1_57,
  input  logic       key_mode_57,
  input  logic       key_select_57,
  input  logic       key_add_57,
  input  logic       key_sub_57,
  output logic [1:0] mode_57,
  output logic       clock_e_57,
  output logic       correct_e_57,
  output logic       alarm_e_57,
  output logic       sw_e_57,
  output logic [2:0] select_57,
  output logic       add_pulse_57,
  output logic       sub_pulse_57
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT_S);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_CORRECT = 2'b01,
    S_ALARM   = 2'b10,
    S_SW      = 2'b11
  } state_t;

  // Key index: 0 mode, 1 select, 2 add, 3 sub
  logic [3:0]       w_raw;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_db;
  logic [3:0]       r_db_q;
  logic [3:0]       r_armed;
  logic [1:0]       r_warm;
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       w_pulse;
  logic             w_mode_p;
  logic             w_sel_p;
  logic             w_add_p;
  logic             w_sub_p;

  logic              r_clk1_q;
  logic              w_clk1_rise;
  state_t            r_state;
  state_t            w_state_nx;
  logic [2:0]        r_select;
  logic [2:0]        w_select_nx;
  logic [IDLE_W-1:0] r_idle;
  logic [IDLE_W-1:0] w_idle_nx;
  logic              w_setting;
  logic [3:0]        r_en;
  logic              r_add;
  logic              r_sub;

  assign w_raw = {key_sub_57, key_add_57, key_select_57, key_mode_57};

  // A key only becomes armed once the filled synchronizer has seen it released,
  // so a button held through reset release never produces a press.
  always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
    if (!rst_n_57) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db_q  <= '0;
      r_armed <= '0;
      r_warm  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
      r_armed <= r_armed | ({4{r_warm == 2'd2}} & ~r_sync2);
    end
  end

  always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
    if (!rst_n_57) begin
      r_db <= '0;
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (r_sync2[k] != r_db[k]) begin
          if (r_cnt[k] == DB_LAST) begin
            r_db[k]  <= r_sync2[k];
            r_cnt[k] <= '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + CNT_W'(1);
          end
        end else begin
          r_cnt[k] <= '0;
        end
      end
    end
  end

  assign w_pulse  = r_db & ~r_db_q & r_armed;
  assign w_mode_p = w_pulse[0];
  assign w_sel_p  = w_pulse[1] & ~w_pulse[0];
  assign w_add_p  = w_pulse[2] & ~|w_pulse[1:0];
  assign w_sub_p  = w_pulse[3] & ~|w_pulse[2:0];

  assign w_clk1_rise = clk_1_57 & ~r_clk1_q;
  assign w_setting   = (r_state == S_CORRECT) || (r_state == S_ALARM);

  always_comb begin
    w_state_nx  = r_state;
    w_select_nx = r_select;
    w_idle_nx   = r_idle;
    if (!w_setting) w_idle_nx = '0;
    if (w_mode_p) begin
      case (r_state)
        S_RUN:     w_state_nx = S_CORRECT;
        S_CORRECT: w_state_nx = S_ALARM;
        S_ALARM:   w_state_nx = S_SW;
        S_SW:      w_state_nx = S_RUN;
        default:   w_state_nx = S_RUN;
      endcase
      if ((w_state_nx == S_CORRECT) || (w_state_nx == S_ALARM)) w_select_nx = 3'b001;
      w_idle_nx = '0;
    end else if (w_setting) begin
      // Leaving at TIMEOUT_V also keeps the counter from ever passing it.
      if (r_idle == TIMEOUT_V) begin
        w_state_nx = S_RUN;
        w_idle_nx  = '0;
      end else if (w_sel_p || w_add_p || w_sub_p) begin
        w_idle_nx = '0;
        if (w_sel_p) w_select_nx = {r_select[1:0], r_select[2]};
      end else if (w_clk1_rise) begin
        w_idle_nx = r_idle + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
    if (!rst_n_57) begin
      r_state  <= S_RUN;
      r_select <= 3'b001;
      r_idle   <= '0;
      r_clk1_q <= 1'b0;
      r_en     <= 4'b0001;
      r_add    <= 1'b0;
      r_sub    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_select <= w_select_nx;
      r_idle   <= w_idle_nx;
      r_clk1_q <= clk_1_57;
      r_en     <= {r_state == S_SW, r_state == S_ALARM, r_state == S_CORRECT, r_state == S_RUN};
      r_add    <= w_add_p & (r_state != S_RUN);
      r_sub    <= w_sub_p & (r_state != S_RUN);
    end
  end

  assign mode_57      = r_state;
  assign clock_e_57   = r_en[0];
  assign correct_e_57 = r_en[1];
  assign alarm_e_57   = r_en[2];
  assign sw_e_57      = r_en[3];
  assign select_57    = r_select;
  assign add_pulse_57 = r_add;
  assign sub_pulse_57 = r_sub;

endmodule

// File: tb/tb_mode_ctrl_57.sv
// Bench for mode_ctrl_57: directed scenarios plus random key presses checked
// against an event-level model of mode, field select and forwarded strobes.
module tb_mode_ctrl_57;
  localparam int DEB = 4;
  localparam int TMO = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk1 = 1'b0;
  logic [3:0] keys = 4'b0000;
  logic [1:0] mode_57;
  logic       clock_e_57, correct_e_57, alarm_e_57, sw_e_57;
  logic [2:0] select_57;
  logic       add_pulse_57, sub_pulse_57;

  mode_ctrl_57 #(.DEBOUNCE_CYC(DEB), .TIMEOUT_S(TMO)) dut (
    .clk_50m_57   (clk),
    .rst_n_57     (rst_n),
    .clk_1_57     (clk1),
    .key_mode_57  (keys[0]),
    .key_select_57(keys[1]),
    .key_add_57   (keys[2]),
    .key_sub_57   (keys[3]),
    .mode_57      (mode_57),
    .clock_e_57   (clock_e_57),
    .correct_e_57 (correct_e_57),
    .alarm_e_57   (alarm_e_57),
    .sw_e_57      (sw_e_57),
    .select_57    (select_57),
    .add_pulse_57 (add_pulse_57),
    .sub_pulse_57 (sub_pulse_57)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_add    = 0;
  int n_sub    = 0;
  int m_mode   = 0;
  int m_sel    = 1;
  int m_add    = 0;
  int m_sub    = 0;

  always @(negedge clk) begin
    if (add_pulse_57) n_add++;
    if (sub_pulse_57) n_sub++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_mode"}, 32'(mode_57), 32'(m_mode));
    check({tag, "_en"}, 32'({sw_e_57, alarm_e_57, correct_e_57, clock_e_57}), 32'(1) << m_mode);
    check({tag, "_sel"}, 32'(select_57), 32'(m_sel));
    check({tag, "_addcnt"}, 32'(n_add), 32'(m_add));
    check({tag, "_subcnt"}, 32'(n_sub), 32'(m_sub));
  endtask

  // Event-level model: one accepted press of key k
  task automatic model_press(input int k);
    bit setting;
    setting = (m_mode == 1) || (m_mode == 2);
    case (k)
      0: begin
        m_mode = (m_mode + 1) % 4;
        if (m_mode == 1 || m_mode == 2) m_sel = 1;
      end
      1: if (setting) m_sel = (m_sel == 4) ? 1 : m_sel * 2;
      2: if (m_mode != 0) m_add++;
      default: if (m_mode != 0) m_sub++;
    endcase
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    keys = m;
    tick(hold);
    keys = 4'b0000;
    tick(12);
  endtask

  task automatic clk1_pulse();
    clk1 = 1'b1;
    tick(3);
    clk1 = 1'b0;
    tick(3);
  endtask

  initial begin
    tick(3);
    check_state("reset");
    check("reset_addp", 32'(add_pulse_57), 32'd0);
    check("reset_subp", 32'(sub_pulse_57), 32'd0);
    rst_n = 1'b1;
    tick(3);

    press(4'b0001, 3);
    check_state("glitch");
    press(4'b0001, 10); model_press(0);
    check_state("to_correct");

    for (int i = 0; i < 3; i++) begin
      press(4'b0010, 10); model_press(1);
      check_state($sformatf("sel%0d", i));
    end
    press(4'b0100, 10); model_press(2);
    check_state("correct_add");

    repeat (3) clk1_pulse();
    m_mode = 0;
    check_state("timeout");

    press(4'b0001, 10); model_press(0);
    check_state("reenter_correct");
    repeat (2) clk1_pulse();
    press(4'b0100, 10); model_press(2);
    repeat (2) clk1_pulse();
    check_state("restart_hold");
    clk1_pulse();
    m_mode = 0;
    check_state("restart_timeout");

    press(4'b0001, 10); model_press(0);
    press(4'b0001, 10); model_press(0);
    check_state("to_alarm");
    press(4'b1100, 10); model_press(2);
    check_state("add_over_sub");
    press(4'b0101, 10); model_press(0);
    check_state("mode_over_add");
    repeat (4) clk1_pulse();
    check_state("sw_no_timeout");
    press(4'b0100, 10); model_press(2);
    press(4'b1000, 10); model_press(3);
    check_state("sw_add_sub");

    press(4'b0001, 10); model_press(0);
    press(4'b0100, 10); model_press(2);
    press(4'b0010, 10); model_press(1);
    check_state("run_gated");

    for (int i = 0; i < 3; i++) begin
      press(4'b0001, 10); model_press(0);
    end
    check_state("to_sw_again");
    keys = 4'b0101;
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    m_mode = 0;
    m_sel  = 1;
    check_state("async_rst");
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check_state("held_through");
    keys = 4'b0000;
    tick(12);
    press(4'b0001, 10); model_press(0);
    check_state("post_rst_press");

    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    m_mode = 0;
    m_sel  = 1;
    tick(3);
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        press(4'(1 << k), $urandom_range(1, 3));
      end else begin
        press(4'(1 << k), $urandom_range(8, 14));
        model_press(k);
      end
      check_state($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
